// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux channel: one-hot grant for a bounded burst,
// with registered select lines that drive the mux select inputs directly.
module mux8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       s1,
  output logic       s2,
  output logic       s3
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [3:0] CntLast = 4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [2:0] cur_q, cur_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;

  logic [2:0] search_start;
  logic [3:0] pick;
  logic       release_grant;

  // Returns {found, index} of the first set bit at or after start, ascending mod 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    // Walk from the farthest offset down so the nearest set bit is written last.
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    release_grant = 1'b0;

    // On release the search starts just past the owner, making it the lowest priority.
    search_start = (state_q == StGrant) ? cur_q + 3'd1 : ptr_q;
    pick         = rr_pick(req, search_start);

    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (en && pick[3]) begin
          state_d = StGrant;
          cur_d   = pick[2:0];
          cnt_d   = '0;
          gnt_d   = 8'b1 << pick[2:0];
        end
      end
      StGrant: begin
        release_grant = !req[cur_q] || (cnt_q == CntLast) || !en;
        if (release_grant) begin
          ptr_d = cur_q + 3'd1;
          if (en && pick[3]) begin
            cur_d = pick[2:0];
            cnt_d = '0;
            gnt_d = 8'b1 << pick[2:0];
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign valid        = (state_q == StGrant);
  // Selects track cur, which only changes on a new grant, so y stays put while idle.
  assign {s3, s2, s1} = cur_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with HOLD_MAX = 4: hand-computed grant sequences
// plus per-cycle invariant checks.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       valid;
  logic       s1, s2, s3;

  int checks;
  int errors;
  bit inv_on;

  mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .req  (req),
    .gnt  (gnt),
    .valid(valid),
    .s1   (s1),
    .s2   (s2),
    .s3   (s3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_sel);
    logic [2:0] sel;
    logic       exp_valid;
    sel       = {s3, s2, s1};
    exp_valid = |exp_gnt;
    checks++;
    assert (gnt === exp_gnt) else begin
      errors++;
      $error("FAIL %s gnt: got %h expected %h", tag, gnt, exp_gnt);
    end
    checks++;
    assert (valid === exp_valid) else begin
      errors++;
      $error("FAIL %s valid: got %b expected %b", tag, valid, exp_valid);
    end
    checks++;
    assert (sel === exp_sel) else begin
      errors++;
      $error("FAIL %s sel: got %0d expected %0d", tag, sel, exp_sel);
    end
  endtask

  // Invariants sampled mid-cycle once the design has seen a reset edge.
  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      assert ((gnt & (gnt - 8'd1)) == 8'd0) else begin
        errors++;
        $error("FAIL inv_onehot: got %h expected zero or one-hot", gnt);
      end
      checks++;
      assert (valid === (|gnt)) else begin
        errors++;
        $error("FAIL inv_valid: got %b expected %b", valid, |gnt);
      end
      if (valid) begin
        checks++;
        assert (gnt[{s3, s2, s1}] === 1'b1) else begin
          errors++;
          $error("FAIL inv_sel: got gnt %h sel %0d expected selected bit set", gnt, {s3, s2, s1});
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    inv_on = 1'b0;
    rst    = 1'b1;
    en     = 1'b1;
    req    = 8'hFF;

    // Reset held for two cycles with everything requesting
    tick();
    inv_on = 1'b1;
    chk("reset1", 8'h00, 3'd0);
    tick();
    chk("reset2", 8'h00, 3'd0);
    rst = 1'b0;
    tick();
    chk("first_grant", 8'h01, 3'd0);

    // Full load: 0..7 then 0 again, four cycles each
    for (int i = 0; i < 36; i++) begin
      chk($sformatf("full_load_%0d", i), 8'b1 << ((i / 4) % 8), 3'((i / 4) % 8));
      tick();
    end

    // Reset mid-grant, then idle with no requests
    rst = 1'b1;
    tick();
    chk("rst_mid_full", 8'h00, 3'd0);
    rst = 1'b0;
    req = 8'h00;
    tick();
    chk("idle_no_req", 8'h00, 3'd0);

    // Single holder re-granted with no gap
    req = 8'h20;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("single_%0d", i), 8'h20, 3'd5);
      tick();
    end
    req = 8'h00;
    chk("single_last", 8'h20, 3'd5);
    tick();
    chk("single_drop_sel_held", 8'h00, 3'd5);

    // Early release: ptr=6, grant 2, then hand off to pending 6
    req = 8'h04;
    tick();
    chk("early_g2", 8'h04, 3'd2);
    req = 8'h44;
    tick();
    chk("early_g2_c1", 8'h04, 3'd2);
    tick();
    chk("early_g2_c2", 8'h04, 3'd2);
    req = 8'h40;
    tick();
    chk("early_handoff_6", 8'h40, 3'd6);
    req = 8'h00;
    tick();
    chk("early_idle", 8'h00, 3'd6);

    // Wrap: ptr=7 with req 0x81 grants 7 then 0
    req = 8'h81;
    tick();
    chk("wrap_g7", 8'h80, 3'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wrap_g7_hold_%0d", i), 8'h80, 3'd7);
    end
    tick();
    chk("wrap_g0", 8'h01, 3'd0);
    req = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wrap_g0_hold_%0d", i), 8'h01, 3'd0);
    end
    tick();
    chk("prio_g1_before_0", 8'h02, 3'd1);
    tick();
    chk("prio_g1_hold", 8'h02, 3'd1);

    // Abort via en: release, selects held, no new grants while low
    en = 1'b0;
    tick();
    chk("abort_en", 8'h00, 3'd1);
    tick();
    chk("abort_blocked", 8'h00, 3'd1);
    en = 1'b1;
    tick();
    chk("abort_resume_g0", 8'h01, 3'd0);

    // Owner drops request: hand off to 1, then reset restarts search at 0
    req = 8'h06;
    tick();
    chk("drop_g1", 8'h02, 3'd1);
    rst = 1'b1;
    req = 8'h03;
    tick();
    chk("rst_mid_grant", 8'h00, 3'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_g0", 8'h01, 3'd0);

    // Request drop coincides with hold expiry: single release, hand off to 1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("simul_hold_%0d", i), 8'h01, 3'd0);
    end
    req = 8'h02;
    tick();
    chk("simul_release_g1", 8'h02, 3'd1);
    req = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("simul_g1_hold_%0d", i), 8'h02, 3'd1);
    end
    tick();
    chk("simul_next_g0", 8'h01, 3'd0);

    inv_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer that shares the 8:1 single-bit `mux8` channel among eight requesters. It grants the channel to one requester at a time, one-hot, for a bounded burst. It drives the mux select lines `s1`/`s2`/`s3` so the granted input `a[i]` appears on the mux output `y`. It sits directly in front of `mux8`, with its select outputs wired straight to the mux select inputs.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles a grant is held; legal range 1..15.

- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `en`  input  1  arbitration enable; low forces release and blocks new grants
- `req`  input  8  request vector; `req[i]` requests mux input `a[i]`
- `gnt`  output  8  one-hot grant; all zero when no grant
- `valid`  output  1  high while a grant is active (`gnt != 0`)
- `s1`  output  1  mux select bit 0 (LSB of granted index)
- `s2`  output  1  mux select bit 1
- `s3`  output  1  mux select bit 2 (MSB)

## Operation
- Internal state:
  - `state` ∈ {IDLE, GRANT}.
  - `cur[2:0]`: granted index.
  - `ptr[2:0]`: highest-priority index for the next arbitration.
  - `cnt[3:0]`: cycles held.
- Arbitration: search `req` starting at `ptr` and ascending mod 8 (`ptr`, `ptr+1`, … 7, 0, …). The first set bit wins.
- IDLE:
  - `gnt` = 0, `valid` = 0.
  - If `en && |req` at the edge: `cur` ← winner, `cnt` ← 0, `gnt` ← one-hot(winner), `valid` ← 1; go to GRANT.
- GRANT, release condition: any of `req[cur]` == 0, `cnt` == `HOLD_MAX`-1, or `en` == 0. Otherwise `cnt` increments.
- On release:
  - `ptr` ← `cur`+1 (mod 8).
  - If `en && |req`, re-arbitrate from `cur`+1 on the same edge. This gives a back-to-back grant with no idle cycle, and `cnt` ← 0.
  - Otherwise go to IDLE.
- Re-grant on release: a current owner still requesting is the lowest priority, reached only by wrap-around. If it is the sole requester, it is re-granted immediately with `cnt` reset.
- Select mapping: `{s3,s2,s1}` = `cur`. Updated only when a new grant is issued. Holds its last value in IDLE so `y` stays stable.
- Simultaneous release causes (for example `req` drop and hold expiry): treated as one release, and `ptr` advances exactly once.
- `req` changes on non-granted bits during GRANT: no effect until the next release.
- Reset state: `state` = IDLE, `ptr` = 0, `cur` = 0, `cnt` = 0.
- Reset values of outputs: `gnt` = 0, `valid` = 0, `s1` = `s2` = `s3` = 0.
- Reset asserted mid-grant: all of the above apply at that edge, and reset takes priority over every other condition.

## Timing
- All outputs are registered; no combinational path from `req`/`en` to outputs.
- Request latency: `req` sampled high at edge N in IDLE → `gnt`/`valid`/selects valid after edge N. Mux output `y` reflects `a[cur]` in the same cycle through `mux8` combinational delay.
- Maximum grant length: `HOLD_MAX` cycles.
- Release plus hand-off: 0 idle cycles when another request is pending at the release edge.
- `en` deassert → `gnt` = 0, `valid` = 0 after the next edge. Selects hold their value.
- Worst-case wait for a continuously asserted requester: 7 × `HOLD_MAX` cycles.
- Invariants, checked every cycle:
  - `gnt` is zero or one-hot.
  - `valid` == `|gnt`.
  - When `valid`, `gnt[{s3,s2,s1}]` == 1.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `req` = 8'hFF, `en` = 1 → `gnt` = 0, `valid` = 0, `{s3,s2,s1}` = 0. After release, first grant is 8'h01 one edge later.
- Single holder, `HOLD_MAX` = 4: `req` = 8'h20 held → `gnt` = 8'h20, selects = 101. Re-granted every 4 cycles with no gap, `valid` never drops.
- Full load: `req` = 8'hFF held → grant order 0,1,2,…,7,0, each held exactly 4 cycles. `{s3,s2,s1}` steps 000…111 and wraps.
- Early release: `req[2]` granted; `req[2]` drops after 2 cycles while `req[6]` pending → `gnt` = 8'h40 next edge, then `ptr` = 7 after `req[6]` releases.
- Wrap and priority: `ptr` = 7, `req` = 8'h81 → grant 7 first, then 0. With `req` = 8'h03 after grant to 0 → grant 1 before 0 again.
- Abort: `en` dropped mid-grant → `gnt` = 0, `valid` = 0 next edge, selects held. Separately, `rst` pulsed mid-grant → full reset values next edge, and the next grant starts search at index 0.
